ctrl_fsm: RTL and testbench

Sequenced control unit that replaces the external-state control decoder. It owns the mode register and the previous-instruction register internally, and collects operand words. Branch targets and immediates can span `EXT_WORDS` instruction words. It sits between the instruction ROM/fetch unit and the datapath (ALU, accumulator/mem register, data memory, LFSR), and produces all per-cycle enables.

---
 rtl/ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Sequenced control unit: decodes instruction words into per-cycle datapath enables.
// Optional LFSR ops and LFSR argument select are enabled by `CTRL_FSM_LFSR_OPS_EN.
module ctrl_fsm #(
   parameter int EXT_WORDS = 1,
   parameter int PCW       = 9,
   parameter int AW        = 9,
   parameter int DW        = 8
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           InstValid,
   input  logic [8:0]     Instruction,
   input  logic [2:0]     CMPBits,
   output logic           BranchEn,
   output logic [PCW-1:0] BranchTarget,
   output logic [2:0]     MemCtl,
   output logic [AW-1:0]  MemoryTarget,
   output logic [3:0]     RegCtl,
   output logic           CMPLoadEn,
   output logic [3:0]     OPCode,
   output logic [1:0]     ALUInput,
   output logic [DW-1:0]  ImmediateOut,
   output logic [2:0]     LFSRCtl,
   output logic           Ack,
   output logic [1:0]     Mode
);

   localparam int OPW = EXT_WORDS * 9;
   localparam int OW  = (EXT_WORDS > 1) ? (EXT_WORDS - 1) * 9 : 1;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_ADM  = 4'd3;
   localparam logic [3:0] OP_RSH  = 4'd4;
   localparam logic [3:0] OP_RSHZ = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_XORA = 4'd9;
   localparam logic [3:0] OP_LSH  = 4'd10;
   localparam logic [3:0] OP_LSHZ = 4'd11;

   typedef enum logic [1:0] {
      S_REG  = 2'b00,
      S_TGT  = 2'b01,
      S_IMM  = 2'b10,
      S_HALT = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [8:0]      prev_q, prev_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [OW-1:0]   opnd_q, opnd_d;
   logic [OPW-1:0]  opr;
   logic            last, cond, shift;
   logic [5:0]      md, mp;
   logic            br_en, mem_we, mem_val, mem_addr;
   logic            reg_clr, acc_clr, reg_ld, acc_ld, cmp_ld, ack;
   logic [3:0]      op;
   logic [1:0]      alu;
   logic [PCW-1:0]  br_tgt;
`ifdef CTRL_FSM_LFSR_OPS_EN
   logic [2:0]      lfsr;
`endif

   // Returns {RegLoad, AccLoad, opcode}; all zero for non-math words.
   function automatic logic [5:0] math_dec(input logic [8:0] w);
      logic [3:0] o;
      o = OP_NONE;
      if (!w[8]) begin
         case (w[7:4])
            4'h1:    o = OP_ADD;
            4'h2:    o = OP_SUB;
            4'h3:    o = OP_ADM;
            4'h4:    o = w[1] ? OP_RSH : OP_RSHZ;
            4'h5:    o = OP_AND;
            4'h6:    o = OP_OR;
            4'h7:    o = OP_XOR;
            4'h8:    o = OP_XORA;
            4'h9:    o = w[1] ? OP_LSH : OP_LSHZ;
            default: o = OP_NONE;
         endcase
      end
      math_dec = {(o != OP_NONE) && (w[7:4] == 4'h3),
                  (o != OP_NONE) && (w[7:4] != 4'h3), o};
   endfunction

   always_comb begin
      opr = (OPW'(opnd_q) << 9) | OPW'(Instruction);
   end

   assign last  = (cnt_q == 2'(EXT_WORDS - 1));
   assign md    = math_dec(Instruction);
   assign mp    = math_dec(prev_q);
   assign shift = (Instruction[7:4] == 4'h4) || (Instruction[7:4] == 4'h9);

   always_comb begin
      unique case (Instruction[6:4])
         3'd0: cond = 1'b1;
         3'd1: cond = CMPBits[2];
         3'd2: cond = CMPBits[0];
         3'd3: cond = CMPBits[0] | CMPBits[1];
         3'd4: cond = ~CMPBits[0];
         3'd5: cond = ~CMPBits[0] | CMPBits[1];
         3'd6: cond = CMPBits[1];
         3'd7: cond = ~CMPBits[1];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      br_en    = 1'b0;
      br_tgt   = PCW'(EXT_WORDS + 1);
      mem_we   = 1'b0;
      mem_val  = 1'b0;
      mem_addr = 1'b0;
      reg_clr  = 1'b0;
      acc_clr  = 1'b0;
      reg_ld   = 1'b0;
      acc_ld   = 1'b0;
      cmp_ld   = 1'b0;
      op       = OP_NONE;
      alu      = 2'b00;
      ack      = (state_q == S_HALT);
`ifdef CTRL_FSM_LFSR_OPS_EN
      lfsr     = 3'b000;
`endif
      if (InstValid) begin
         case (state_q)
            S_REG: begin
               prev_d = Instruction;
               if (Instruction[8]) begin
                  if (Instruction[7]) begin
                     if (cond) state_d = S_TGT;
                     else      br_en   = 1'b1;
                  end
               end else if (Instruction[7:4] == 4'h0) begin
                  case (Instruction[3:0])
                     4'h1: acc_clr = 1'b1;
                     4'h2: reg_clr = 1'b1;
`ifdef CTRL_FSM_LFSR_OPS_EN
                     4'h3: lfsr = 3'b001;
                     4'h4: lfsr = 3'b010;
                     4'h5: lfsr = 3'b100;
`endif
                     4'h6: begin
                        op     = OP_ADD;
                        alu    = 2'b01;
                        acc_ld = 1'b1;
                     end
                     4'h8: cmp_ld = 1'b1;
                     4'hC, 4'hD: state_d = S_TGT;
                     4'hE: begin
                        mem_we  = 1'b1;
                        mem_val = 1'b1;
                     end
                     4'hF: begin
                        ack     = 1'b1;
                        state_d = S_HALT;
                     end
                     default: ;
                  endcase
               end else if (md[3:0] != OP_NONE) begin
                  case (Instruction[3:2])
                     2'b00: {reg_ld, acc_ld, op} = md;
                     2'b01: state_d = S_TGT;
                     2'b10: state_d = S_IMM;
                     2'b11: begin
`ifdef CTRL_FSM_LFSR_OPS_EN
                        if (!shift) begin
                           {reg_ld, acc_ld, op} = md;
                           alu = 2'b11;
                        end
`endif
                     end
                  endcase
               end
            end
            S_TGT, S_IMM: begin
               if (!last) begin
                  opnd_d = OW'(opr);
                  cnt_d  = cnt_q + 2'd1;
               end else begin
                  opnd_d  = '0;
                  cnt_d   = 2'd0;
                  state_d = S_REG;
                  if (state_q == S_IMM) begin
                     {reg_ld, acc_ld, op} = mp;
                     alu = 2'b10;
                  end else if (prev_q[8]) begin
                     br_en  = 1'b1;
                     br_tgt = PCW'(opr);
                  end else begin
                     {reg_ld, acc_ld, op} = mp;
                     alu      = 2'b01;
                     mem_addr = 1'b1;
                     // Stores: C writes the accumulator value, D the raw path.
                     if (prev_q == 9'h00C) begin
                        mem_we  = 1'b1;
                        mem_val = 1'b1;
                     end else if (prev_q == 9'h00D) begin
                        mem_we  = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_REG;
         prev_q  <= '0;
         cnt_q   <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
      end
   end

   assign BranchEn     = br_en;
   assign BranchTarget = br_tgt;
   assign MemCtl       = {mem_we, mem_val, mem_addr};
   assign MemoryTarget = AW'(opr);
   assign RegCtl       = {reg_clr, acc_clr, reg_ld, acc_ld};
   assign CMPLoadEn    = cmp_ld;
   assign OPCode       = op;
   assign ALUInput     = alu;
   assign ImmediateOut = DW'(opr);
   assign Ack          = ack;
   assign Mode         = state_q;
`ifdef CTRL_FSM_LFSR_OPS_EN
   assign LFSRCtl      = lfsr;
`else
   assign LFSRCtl      = 3'b000;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: directed program fragments then random words,
// predicted by a word-queue reference model.
module tb_ctrl_fsm;

   localparam int EXT = 2;
   localparam int PCW = 16;
   localparam int AW  = 9;
   localparam int DW  = 8;
`ifdef CTRL_FSM_LFSR_OPS_EN
   localparam bit LFSR_EN = 1'b1;
`else
   localparam bit LFSR_EN = 1'b0;
`endif

   logic           Clk = 1'b0;
   logic           Reset_n = 1'b0;
   logic           InstValid = 1'b0;
   logic [8:0]     Instruction = '0;
   logic [2:0]     CMPBits = '0;
   logic           BranchEn;
   logic [PCW-1:0] BranchTarget;
   logic [2:0]     MemCtl;
   logic [AW-1:0]  MemoryTarget;
   logic [3:0]     RegCtl;
   logic           CMPLoadEn;
   logic [3:0]     OPCode;
   logic [1:0]     ALUInput;
   logic [DW-1:0]  ImmediateOut;
   logic [2:0]     LFSRCtl;
   logic           Ack;
   logic [1:0]     Mode;

   always #5 Clk = ~Clk;

   ctrl_fsm #(.EXT_WORDS(EXT), .PCW(PCW), .AW(AW), .DW(DW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .InstValid(InstValid),
      .Instruction(Instruction), .CMPBits(CMPBits),
      .BranchEn(BranchEn), .BranchTarget(BranchTarget), .MemCtl(MemCtl),
      .MemoryTarget(MemoryTarget), .RegCtl(RegCtl), .CMPLoadEn(CMPLoadEn),
      .OPCode(OPCode), .ALUInput(ALUInput), .ImmediateOut(ImmediateOut),
      .LFSRCtl(LFSRCtl), .Ack(Ack), .Mode(Mode)
   );

   typedef struct packed {
      logic           br;
      logic [PCW-1:0] bt;
      logic [2:0]     mem;
      logic [AW-1:0]  mt;
      logic [3:0]     rg;
      logic           cl;
      logic [3:0]     op;
      logic [1:0]     alu;
      logic [DW-1:0]  im;
      logic [2:0]     lf;
      logic           ack;
      logic [1:0]     md;
   } out_t;

   out_t expq[$];
   int   idq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   stepno = 0;

   // Model state: 0 REG, 1 TGT, 2 IMM, 3 HALT; operand words gathered so far.
   int         m_mode = 0;
   logic [8:0] m_prev = '0;
   logic [8:0] m_words[$];

   function automatic logic [3:0] alu_op(logic [3:0] nib, logic b1);
      case (nib)
         4'h1: return 4'd1;
         4'h2: return 4'd2;
         4'h3: return 4'd3;
         4'h4: return b1 ? 4'd4 : 4'd5;
         4'h5: return 4'd6;
         4'h6: return 4'd7;
         4'h7: return 4'd8;
         4'h8: return 4'd9;
         4'h9: return b1 ? 4'd10 : 4'd11;
         default: return 4'd0;
      endcase
   endfunction

   function automatic bit taken(logic [3:0] nib, logic [2:0] f);
      bit z = f[2];
      bit eq = f[1];
      bit gt = f[0];
      case (nib)
         4'h8: return 1'b1;
         4'h9: return z;
         4'hA: return gt;
         4'hB: return gt | eq;
         4'hC: return !gt;
         4'hD: return !gt | eq;
         4'hE: return eq;
         default: return !eq;
      endcase
   endfunction

   function automatic out_t predict(logic v, logic [8:0] w, logic [2:0] f);
      out_t o;
      longint unsigned val = 0;
      logic [3:0] nib = w[7:4];
      logic [3:0] pn = m_prev[7:4];
      logic [3:0] ld;
      o = '0;
      foreach (m_words[i]) val = val * 512 + m_words[i];
      val = val * 512 + w;
      o.bt  = PCW'(EXT + 1);
      o.mt  = AW'(val);
      o.im  = DW'(val);
      o.md  = 2'(m_mode);
      o.ack = (m_mode == 3);
      if (!v || m_mode == 3) return o;
      if (m_mode == 0) begin
         if (w[8]) begin
            if (nib >= 8 && !taken(nib, f)) o.br = 1'b1;
         end else if (nib == 0) begin
            case (w[3:0])
               4'h1: o.rg = 4'b0100;
               4'h2: o.rg = 4'b1000;
               4'h3: if (LFSR_EN) o.lf = 3'b001;
               4'h4: if (LFSR_EN) o.lf = 3'b010;
               4'h5: if (LFSR_EN) o.lf = 3'b100;
               4'h6: begin o.op = 4'd1; o.alu = 2'b01; o.rg = 4'b0001; end
               4'h8: o.cl = 1'b1;
               4'hE: o.mem = 3'b110;
               4'hF: o.ack = 1'b1;
               default: ;
            endcase
         end else if (nib <= 9) begin
            ld = (nib == 3) ? 4'b0010 : 4'b0001;
            if (w[3:2] == 2'b00) begin
               o.op = alu_op(nib, w[1]);
               o.rg = ld;
            end else if (w[3:2] == 2'b11 && LFSR_EN && nib != 4 && nib != 9) begin
               o.op  = alu_op(nib, w[1]);
               o.rg  = ld;
               o.alu = 2'b11;
            end
         end
      end else if (m_words.size() == EXT - 1) begin
         if (m_mode == 1 && m_prev[8]) begin
            o.br = 1'b1;
            o.bt = PCW'(val);
         end else begin
            o.op = alu_op(pn, m_prev[1]);
            if (o.op != 0) o.rg = (pn == 3) ? 4'b0010 : 4'b0001;
            if (m_mode == 2) o.alu = 2'b10;
            else begin
               o.alu = 2'b01;
               o.mem = 3'b001;
               if (m_prev == 9'h00C) o.mem = 3'b111;
               if (m_prev == 9'h00D) o.mem = 3'b101;
            end
         end
      end
      return o;
   endfunction

   function automatic void advance(logic v, logic [8:0] w, logic [2:0] f);
      logic [3:0] nib = w[7:4];
      if (!v) return;
      case (m_mode)
         0: begin
            m_prev = w;
            if (w[8]) begin
               if (nib >= 8 && taken(nib, f)) m_mode = 1;
            end else if (nib == 0) begin
               if (w[3:0] == 4'hC || w[3:0] == 4'hD) m_mode = 1;
               else if (w[3:0] == 4'hF) m_mode = 3;
            end else if (nib <= 9) begin
               if (w[3:2] == 2'b01) m_mode = 1;
               else if (w[3:2] == 2'b10) m_mode = 2;
            end
         end
         1, 2: begin
            if (m_words.size() == EXT - 1) begin
               m_words.delete();
               m_mode = 0;
            end else m_words.push_back(w);
         end
         default: ;
      endcase
   endfunction

   task automatic step(input logic v, input logic [8:0] w,
                       input logic [2:0] f, input logic rst);
      @(posedge Clk);
      #1;
      if (rst) begin
         Reset_n = 1'b0;
         m_mode = 0;
         m_prev = '0;
         m_words.delete();
      end
      InstValid   = v;
      Instruction = w;
      CMPBits     = f;
      expq.push_back(predict(v, w, f));
      idq.push_back(stepno);
      stepno++;
      advance(v, w, f);
      if (rst) begin
         @(negedge Clk);
         #1 Reset_n = 1'b1;
      end
   endtask

   always @(negedge Clk) begin
      out_t e, g;
      int id;
      if (expq.size() > 0) begin
         e  = expq.pop_front();
         id = idq.pop_front();
         g  = {BranchEn, BranchTarget, MemCtl, MemoryTarget, RegCtl, CMPLoadEn,
               OPCode, ALUInput, ImmediateOut, LFSRCtl, Ack, Mode};
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL outputs step %0d: got br=%b bt=%h mem=%b mt=%h rg=%b cl=%b op=%0d alu=%b im=%h lf=%b ack=%b md=%b | want br=%b bt=%h mem=%b mt=%h rg=%b cl=%b op=%0d alu=%b im=%h lf=%b ack=%b md=%b",
                     id, g.br, g.bt, g.mem, g.mt, g.rg, g.cl, g.op, g.alu, g.im, g.lf, g.ack, g.md,
                     e.br, e.bt, e.mem, e.mt, e.rg, e.cl, e.op, e.alu, e.im, e.lf, e.ack, e.md);
         end
      end
   end

   initial begin
      logic [8:0] w;
      logic [3:0] nib;
      int r;
      step(0, 9'h000, 3'b000, 1);
      step(1, 9'h1E0, 3'b000, 0);
      step(1, 9'h180, 3'b000, 0);
      step(1, 9'h001, 3'b000, 0);
      step(0, 9'h0AA, 3'b000, 0);
      step(1, 9'h023, 3'b000, 0);
      step(1, 9'h1E0, 3'b010, 0);
      step(1, 9'h000, 3'b000, 0);
      step(1, 9'h055, 3'b000, 0);
      step(1, 9'h098, 3'b000, 0);
      step(1, 9'h000, 3'b000, 0);
      step(1, 9'h003, 3'b000, 0);
      step(1, 9'h00C, 3'b000, 0);
      step(1, 9'h012, 3'b000, 0);
      step(0, 9'h055, 3'b000, 1);
      step(1, 9'h000, 3'b000, 0);
      step(1, 9'h005, 3'b000, 0);
      step(1, 9'h03F, 3'b000, 0);
      step(1, 9'h014, 3'b000, 0);
      step(1, 9'h00E, 3'b000, 0);
      step(1, 9'h00F, 3'b000, 0);
      step(1, 9'h011, 3'b000, 0);
      step(0, 9'h011, 3'b000, 0);
      step(1, 9'h011, 3'b000, 1);
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 9);
         nib = 4'($urandom_range(1, 9));
         case (r)
            0, 1, 2: w = {2'b11, 7'($urandom)};
            3:       w = {5'b00000, 4'($urandom_range(0, 14))};
            4, 5, 6, 7: w = {1'b0, nib, 4'($urandom)};
            default: w = 9'($urandom);
         endcase
         step(($urandom_range(0, 99) < 85), w, 3'($urandom),
              ($urandom_range(0, 39) == 0));
      end
      repeat (3) @(posedge Clk);
      if (expq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
